param_pp_buf: RTL and testbench

//  Next-generation parameter ping-pong buffer holding per-output-channel {bias, HBM, LBM} entries for the PU.
//  The previous generation swapped banks on an external buf_pp_flag. This block owns the swap itself:
//  AXI fills one bank while the PU reads the other, and a fill/consume handshake decides when banks swap.

---
 rtl/param_buf_pkg.sv | 23 ++
 rtl/dp_ram.sv | 23 ++
 rtl/param_pp_ctrl.sv | 93 +++++++++
 rtl/param_pp_buf.sv | 106 ++++++++++
 tb/tb_param_pp_buf.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/param_buf_pkg.sv
// rtl/param_buf_pkg.sv - field widths, packing helpers and field offsets for the parameter ping-pong buffer
package param_buf_pkg;

  localparam int DEF_BIAS_WIDTH = 16;
  localparam int DEF_HBM_WIDTH  = 16;
  localparam int DEF_LBM_WIDTH  = 16;
  localparam int DEF_OC_NUM     = 4;
  localparam int DEF_DEPTH      = 32;

  // Channel entry layout: LBM in the low bits, bias at the top.
  localparam int LBM_LSB  = 0;
  localparam int HBM_LSB  = DEF_LBM_WIDTH;
  localparam int BIAS_LSB = DEF_LBM_WIDTH + DEF_HBM_WIDTH;

  function automatic int entry_width(input int bias_w, input int hbm_w, input int lbm_w);
    return bias_w + hbm_w + lbm_w;
  endfunction

  function automatic int buf_width(input int entry_w, input int oc_num);
    return entry_w * oc_num;
  endfunction

endpackage

// File: rtl/dp_ram.sv
// rtl/dp_ram.sv - simple dual-port RAM, one write port and one registered read port (read-first)
module dp_ram #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 192,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_pp_ctrl.sv
// rtl/param_pp_ctrl.sv - bank ownership (wr_sel/rd_sel/full), request accept and sticky error logic
module param_pp_ctrl #(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  load_done,
  input  logic                  axi_ren,
  input  logic [ADDR_WIDTH-1:0] axi_raddr,
  input  logic                  pu_ren,
  input  logic [ADDR_WIDTH-1:0] pu_raddr,
  input  logic                  pu_done,
  output logic                  wr_acc,
  output logic                  axi_rd_acc,
  output logic                  pu_rd_acc,
  output logic                  wr_sel,
  output logic                  rd_sel,
  output logic                  wr_rdy,
  output logic                  ready,
  output logic                  axi_rvalid,
  output logic                  pu_rvalid,
  output logic                  axi_bank,
  output logic                  pu_bank,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

  logic [1:0] full;
  logic [1:0] full_n;
  logic       load_acc;
  logic       done_acc;
  logic       wr_drop;
  logic       rd_drop;

  assign wr_rdy = ~full[wr_sel];
  assign ready  = full[rd_sel];

  assign wr_acc     = wen     & wr_rdy & ({1'b0, waddr}     < DEPTH_W);
  assign axi_rd_acc = axi_ren & wr_rdy & ({1'b0, axi_raddr} < DEPTH_W);
  assign pu_rd_acc  = pu_ren  & ready  & ({1'b0, pu_raddr}  < DEPTH_W);
  assign load_acc   = load_done & wr_rdy;
  assign done_acc   = pu_done   & ready;

  assign wr_drop = (wen & ~wr_acc) | (axi_ren & ~axi_rd_acc) | (load_done & ~wr_rdy);
  assign rd_drop = (pu_ren & ~pu_rd_acc) | (pu_done & ~ready);

  // Load is applied after release so a same-bank collision leaves the bank full.
  always_comb begin
    full_n = full;
    if (done_acc) full_n[rd_sel] = 1'b0;
    if (load_acc) full_n[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      full       <= 2'b00;
      axi_rvalid <= 1'b0;
      pu_rvalid  <= 1'b0;
      axi_bank   <= 1'b0;
      pu_bank    <= 1'b0;
      wr_err     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      if (flush) begin
        wr_sel     <= 1'b0;
        rd_sel     <= 1'b0;
        full       <= 2'b00;
        axi_rvalid <= 1'b0;
        pu_rvalid  <= 1'b0;
      end else begin
        full       <= full_n;
        if (load_acc) wr_sel <= ~wr_sel;
        if (done_acc) rd_sel <= ~rd_sel;
        axi_rvalid <= axi_rd_acc;
        pu_rvalid  <= pu_rd_acc;
      end
      // Bank captured at accept keeps the returned data stable across a swap.
      if (axi_rd_acc) axi_bank <= wr_sel;
      if (pu_rd_acc)  pu_bank  <= rd_sel;
      if (wr_drop)    wr_err   <= 1'b1;
      if (rd_drop)    rd_err   <= 1'b1;
    end
  end

endmodule

// File: rtl/param_pp_buf.sv
// rtl/param_pp_buf.sv - self-swapping parameter ping-pong buffer: AXI fills one bank while the PU reads the other
module param_pp_buf
  import param_buf_pkg::*;
#(
  parameter int BIAS_DATA_WIDTH = DEF_BIAS_WIDTH,
  parameter int HBM_DATA_WIDTH  = DEF_HBM_WIDTH,
  parameter int LBM_DATA_WIDTH  = DEF_LBM_WIDTH,
  parameter int OC_NUM          = DEF_OC_NUM,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int ADDR_WIDTH      = $clog2(DEPTH),
  parameter int ENTRY_WIDTH     = entry_width(BIAS_DATA_WIDTH, HBM_DATA_WIDTH, LBM_DATA_WIDTH),
  parameter int BUF_WIDTH       = buf_width(ENTRY_WIDTH, OC_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_flush,
  input  logic                  axi2p_wen,
  input  logic [ADDR_WIDTH-1:0] axi2p_waddr,
  input  logic [BUF_WIDTH-1:0]  axi2p_wdata,
  input  logic                  axi2p_load_done,
  input  logic                  axi2p_ren,
  input  logic [ADDR_WIDTH-1:0] axi2p_raddr,
  output logic [BUF_WIDTH-1:0]  p2axi_rdata,
  output logic                  p2axi_rvalid,
  output logic                  p2axi_wr_rdy,
  input  logic                  pu2p_ren,
  input  logic [ADDR_WIDTH-1:0] pu2p_raddr,
  input  logic                  pu2p_done,
  output logic                  p2pu_ready,
  output logic [BUF_WIDTH-1:0]  p2pu_rdata,
  output logic                  p2pu_rvalid,
  output logic                  p_wr_err,
  output logic                  p_rd_err
);

  logic wr_acc;
  logic axi_rd_acc;
  logic pu_rd_acc;
  logic wr_sel;
  logic rd_sel;
  logic axi_bank;
  logic pu_bank;

  logic [BUF_WIDTH-1:0] bank_rdata [2];

  param_pp_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .flush      (p_flush),
    .wen        (axi2p_wen),
    .waddr      (axi2p_waddr),
    .load_done  (axi2p_load_done),
    .axi_ren    (axi2p_ren),
    .axi_raddr  (axi2p_raddr),
    .pu_ren     (pu2p_ren),
    .pu_raddr   (pu2p_raddr),
    .pu_done    (pu2p_done),
    .wr_acc     (wr_acc),
    .axi_rd_acc (axi_rd_acc),
    .pu_rd_acc  (pu_rd_acc),
    .wr_sel     (wr_sel),
    .rd_sel     (rd_sel),
    .wr_rdy     (p2axi_wr_rdy),
    .ready      (p2pu_ready),
    .axi_rvalid (p2axi_rvalid),
    .pu_rvalid  (p2pu_rvalid),
    .axi_bank   (axi_bank),
    .pu_bank    (pu_bank),
    .wr_err     (p_wr_err),
    .rd_err     (p_rd_err)
  );

  // Readback targets the fill bank and PU reads the owned bank, so one read port per bank suffices.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic SEL = 1'(b);

    logic                  pu_hit;
    logic                  axi_hit;
    logic [ADDR_WIDTH-1:0] raddr;

    assign pu_hit  = pu_rd_acc  & (rd_sel == SEL);
    assign axi_hit = axi_rd_acc & (wr_sel == SEL);
    assign raddr   = pu_hit ? pu2p_raddr : axi2p_raddr;

    dp_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (BUF_WIDTH),
      .DEPTH      (DEPTH)
    ) u_ram (
      .clk   (clk),
      .wen   (wr_acc & (wr_sel == SEL)),
      .waddr (axi2p_waddr),
      .wdata (axi2p_wdata),
      .ren   (pu_hit | axi_hit),
      .raddr (raddr),
      .rdata (bank_rdata[b])
    );
  end

  assign p2pu_rdata  = bank_rdata[pu_bank];
  assign p2axi_rdata = bank_rdata[axi_bank];

endmodule

// File: tb/tb_param_pp_buf.sv
// tb/tb_param_pp_buf.sv - directed self-checking bench for param_pp_buf
module tb_param_pp_buf;

  localparam int DEPTH = 24;
  localparam int AW    = 5;
  localparam int BW    = 192;

  logic          clk;
  logic          rst;
  logic          p_flush;
  logic          axi2p_wen;
  logic [AW-1:0] axi2p_waddr;
  logic [BW-1:0] axi2p_wdata;
  logic          axi2p_load_done;
  logic          axi2p_ren;
  logic [AW-1:0] axi2p_raddr;
  logic [BW-1:0] p2axi_rdata;
  logic          p2axi_rvalid;
  logic          p2axi_wr_rdy;
  logic          pu2p_ren;
  logic [AW-1:0] pu2p_raddr;
  logic          pu2p_done;
  logic          p2pu_ready;
  logic [BW-1:0] p2pu_rdata;
  logic          p2pu_rvalid;
  logic          p_wr_err;
  logic          p_rd_err;

  int n_checks = 0;
  int n_pass   = 0;

  param_pp_buf #(
    .DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .p_flush         (p_flush),
    .axi2p_wen       (axi2p_wen),
    .axi2p_waddr     (axi2p_waddr),
    .axi2p_wdata     (axi2p_wdata),
    .axi2p_load_done (axi2p_load_done),
    .axi2p_ren       (axi2p_ren),
    .axi2p_raddr     (axi2p_raddr),
    .p2axi_rdata     (p2axi_rdata),
    .p2axi_rvalid    (p2axi_rvalid),
    .p2axi_wr_rdy    (p2axi_wr_rdy),
    .pu2p_ren        (pu2p_ren),
    .pu2p_raddr      (pu2p_raddr),
    .pu2p_done       (pu2p_done),
    .p2pu_ready      (p2pu_ready),
    .p2pu_rdata      (p2pu_rdata),
    .p2pu_rvalid     (p2pu_rvalid),
    .p_wr_err        (p_wr_err),
    .p_rd_err        (p_rd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [BW-1:0] rep(input logic [7:0] b);
    return {24{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] d);
    axi2p_wen = 1'b1; axi2p_waddr = a; axi2p_wdata = d;
    tick();
    axi2p_wen = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 4; i++) wr(AW'(i), rep(base + 8'(i)));
  endtask

  task automatic load();
    axi2p_load_done = 1'b1;
    tick();
    axi2p_load_done = 1'b0;
  endtask

  task automatic pu_done();
    pu2p_done = 1'b1;
    tick();
    pu2p_done = 1'b0;
  endtask

  task automatic pu_rd(input logic [AW-1:0] a);
    pu2p_ren = 1'b1; pu2p_raddr = a;
    tick();
    pu2p_ren = 1'b0;
  endtask

  task automatic axi_rd(input logic [AW-1:0] a);
    axi2p_ren = 1'b1; axi2p_raddr = a;
    tick();
    axi2p_ren = 1'b0;
  endtask

  initial begin
    rst = 1'b1; p_flush = 1'b0;
    axi2p_wen = 1'b0; axi2p_waddr = '0; axi2p_wdata = '0; axi2p_load_done = 1'b0;
    axi2p_ren = 1'b0; axi2p_raddr = '0;
    pu2p_ren = 1'b0; pu2p_raddr = '0; pu2p_done = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_wr_rdy", p2axi_wr_rdy, 1);
    check("rst_ready", p2pu_ready, 0);
    check("rst_pu_rvalid", p2pu_rvalid, 0);
    check("rst_axi_rvalid", p2axi_rvalid, 0);
    check("rst_errs", {p_wr_err, p_rd_err}, 0);

    // fill bank0, hand over, PU read
    fill(8'hA0);
    load();
    check("t1_ready", p2pu_ready, 1);
    check("t1_wr_rdy", p2axi_wr_rdy, 1);
    pu_rd(2);
    check("t1_rvalid", p2pu_rvalid, 1);
    check("t1_rdata", p2pu_rdata, rep(8'hA2));
    tick();
    check("t1_rvalid_drop", p2pu_rvalid, 0);

    // simultaneous load_done and pu2p_done on different banks
    fill(8'hB0);
    axi2p_load_done = 1'b1; pu2p_done = 1'b1;
    tick();
    axi2p_load_done = 1'b0; pu2p_done = 1'b0;
    check("t3_ready", p2pu_ready, 1);
    check("t3_wr_rdy", p2axi_wr_rdy, 1);
    check("t3_errs", {p_wr_err, p_rd_err}, 0);
    pu_rd(3);
    check("t3_rdata", p2pu_rdata, rep(8'hB3));

    // both banks full, write dropped, then swap
    fill(8'hC0);
    load();
    check("t2_wr_rdy_full", p2axi_wr_rdy, 0);
    check("t2_ready", p2pu_ready, 1);
    pu_rd(1);
    check("t2_rdata_b", p2pu_rdata, rep(8'hB1));
    wr(0, rep(8'hD0));
    check("t2_wr_err", p_wr_err, 1);
    pu_done();
    check("t2_ready_after", p2pu_ready, 1);
    check("t2_wr_rdy_after", p2axi_wr_rdy, 1);
    pu_rd(0);
    check("t2_rdata_c", p2pu_rdata, rep(8'hC0));
    axi_rd(0);
    check("t2_rb_valid", p2axi_rvalid, 1);
    check("t2_rb_data", p2axi_rdata, rep(8'hB0));
    check("t2_rd_err", p_rd_err, 0);

    // PU read in the same cycle as pu2p_done returns pre-swap bank data
    fill(8'hE0);
    load();
    pu2p_ren = 1'b1; pu2p_raddr = 2; pu2p_done = 1'b1;
    tick();
    pu2p_ren = 1'b0; pu2p_done = 1'b0;
    check("t5_rvalid", p2pu_rvalid, 1);
    check("t5_rdata", p2pu_rdata, rep(8'hC2));
    pu_rd(2);
    check("t5_rdata_new", p2pu_rdata, rep(8'hE2));

    // dropped PU read and out-of-range write after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_errs_clr", {p_wr_err, p_rd_err}, 0);
    check("t4_ready", p2pu_ready, 0);
    pu_rd(1);
    check("t4_no_rvalid", p2pu_rvalid, 0);
    check("t4_rd_err", p_rd_err, 1);
    check("t4_wr_err_pre", p_wr_err, 0);
    wr(AW'(DEPTH), rep(8'hF0));
    check("t4_wr_err", p_wr_err, 1);
    axi_rd(AW'(DEPTH));
    check("t4_rb_oor", p2axi_rvalid, 0);
    axi_rd(0);
    check("t4_ram_kept", p2axi_rdata, rep(8'hC0));

    // read-first on same-address write and readback
    axi2p_wen = 1'b1; axi2p_waddr = 1; axi2p_wdata = rep(8'h11);
    axi2p_ren = 1'b1; axi2p_raddr = 1;
    tick();
    axi2p_wen = 1'b0; axi2p_ren = 1'b0;
    check("rf_old", p2axi_rdata, rep(8'hC1));
    axi_rd(1);
    check("rf_new", p2axi_rdata, rep(8'h11));

    // async reset with readback in flight
    wr(2, rep(8'h22));
    axi_rd(2);
    check("t6_rvalid_pre", p2axi_rvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rvalid_async", p2axi_rvalid, 0);
    check("t6_wr_rdy", p2axi_wr_rdy, 1);
    check("t6_ready", p2pu_ready, 0);
    check("t6_errs", {p_wr_err, p_rd_err}, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_errs_rel", {p_wr_err, p_rd_err}, 0);

    // flush: bank state cleared, error flags persist
    pu_rd(0);
    check("fl_rd_err", p_rd_err, 1);
    wr(0, rep(8'h33));
    load();
    check("fl_ready_pre", p2pu_ready, 1);
    pu_rd(0);
    check("fl_rdata", p2pu_rdata, rep(8'h33));
    p_flush = 1'b1; pu2p_ren = 1'b1; pu2p_raddr = 0;
    tick();
    p_flush = 1'b0; pu2p_ren = 1'b0;
    check("fl_rvalid", p2pu_rvalid, 0);
    check("fl_ready", p2pu_ready, 0);
    check("fl_wr_rdy", p2axi_wr_rdy, 1);
    check("fl_rd_err_kept", p_rd_err, 1);
    check("fl_wr_err", p_wr_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
